// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word/mask types and the data-memory responder state encoding.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with per-byte write enables and a registered read port.
module dmem_array
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           re,
  input  logic           rclr,
  input  logic           we,
  input  rv32i_mem_wmask be,
  input  logic [AW-1:0]  idx,
  input  rv32i_word      wdata,
  output rv32i_word      rdata
);
  logic [3:0][7:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][i] <= wdata[8*i +: 8];
  end
  // Contents are never reset; only the read register is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= rclr ? '0 : mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency behavioural data memory for the RV32I MEM stage.
// Optional DMEM_ERR_EN flags out-of-range accesses on mem_err instead of wrapping them.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_word      mem_address,
  input  rv32i_word      mem_wdata,
  input  rv32i_mem_wmask mem_byte_enable,
  output rv32i_word      mem_rdata,
  output logic           mem_resp
`ifdef DMEM_ERR_EN
  , output logic         mem_err
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  dmem_state_t    state;
  logic [CW-1:0]  cnt;
  rv32i_word      addr_q, wdata_q;
  rv32i_mem_wmask be_q;
  logic           wr_q;
  logic           idle, req, go_done, sel_wr, oob;
  rv32i_word      sel_addr, sel_wdata;
  rv32i_mem_wmask sel_be;
  logic [AW-1:0]  idx;
  // With LATENCY==1 the access completes on the sampling edge, so the live inputs feed the array.
  always_comb begin
    idle      = state == IDLE;
    req       = mem_read | mem_write;
    sel_addr  = idle ? mem_address : addr_q;
    sel_wdata = idle ? mem_wdata : wdata_q;
    sel_be    = idle ? mem_byte_enable : be_q;
    sel_wr    = idle ? mem_write : wr_q;
    go_done   = idle ? (req && LATENCY == 1) : (state == WAIT && cnt == '0);
    idx       = AW'((sel_addr - BASE_ADDR) >> 2);
  end
`ifdef DMEM_ERR_EN
  assign oob = ({1'b0, sel_addr} < {1'b0, BASE_ADDR}) ||
               ({1'b0, sel_addr} >= {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err <= 1'b0;
    else mem_err <= go_done & oob;
  end
`else
  assign oob = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_resp <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      mem_resp <= go_done;
      if (idle && req) begin
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
        state   <= (LATENCY == 1) ? DONE : WAIT;
        cnt     <= (LATENCY == 1) ? cnt : CW'(LATENCY - 2);
      end else if (state == WAIT) begin
        if (cnt == '0) state <= DONE;
        else cnt <= cnt - 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .re    (go_done & ~sel_wr),
    .rclr  (oob),
    .we    (go_done & sel_wr & ~oob),
    .be    (sel_be),
    .idx   (idx),
    .wdata (sel_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on a LATENCY=3 and a LATENCY=1 responder (DMEM_ERR_EN aware).
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  logic a_read, a_write, a_resp, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0] a_be;
  logic b_read, b_write, b_resp;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0] b_be;
  int n_cmp = 0, n_bad = 0;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
  logic b_err;
`else
  localparam bit ERR_EN = 1'b0;
  assign a_err = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(a_write),
    .mem_address(a_addr), .mem_wdata(a_wdata), .mem_byte_enable(a_be),
    .mem_rdata(a_rdata), .mem_resp(a_resp)
`ifdef DMEM_ERR_EN
    , .mem_err(a_err)
`endif
  );
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_read), .mem_write(b_write),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
    .mem_rdata(b_rdata), .mem_resp(b_resp)
`ifdef DMEM_ERR_EN
    , .mem_err(b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output int lat, output logic [31:0] rd,
                       output logic err);
    a_read = !wr; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
    lat = 0; rd = 'x; err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (a_resp) begin lat = c; rd = a_rdata; err = a_err; break; end
    end
    a_read = 1'b0; a_write = 1'b0;
    @(posedge clk); #1;
    check("a_resp_one_cycle", a_resp, 0);
  endtask

  task automatic req_b(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output int lat);
    b_read = !wr; b_write = wr; b_addr = addr; b_wdata = wd; b_be = be; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (b_resp) begin lat = c; break; end
    end
    b_read = 1'b0; b_write = 1'b0;
    @(posedge clk); #1;
    check("b_resp_one_cycle", b_resp, 0);
  endtask

  initial begin
    int lat, hits;
    logic [31:0] rd;
    logic err;
    logic [31:0] bval [1:3];
    bval[1] = 32'h1111_1111; bval[2] = 32'h2222_2222; bval[3] = 32'h3333_3333;
    rst = 1'b1;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_resp", a_resp, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_resp", b_resp, 0);
    rst = 1'b0;
    hits = 0;
    repeat (20) begin @(posedge clk); #1; hits += int'(a_resp) + int'(b_resp); end
    check("idle_no_resp", hits, 0);

    req_a(1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, err);
    check("wr_latency", lat, 3);
    check("wr_keeps_rdata", a_rdata, 0);
    req_a(0, 32'h10, 0, 0, lat, rd, err);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);

    req_a(1, 32'h14, 32'hFFFF_FFFF, 4'hF, lat, rd, err);
    req_a(1, 32'h14, 32'h1122_3344, 4'b0101, lat, rd, err);
    req_a(0, 32'h14, 0, 0, lat, rd, err);
    check("lanes_0101", rd, 32'hFF22_FF44);
    req_a(1, 32'h14, 32'h0000_0000, 4'b0000, lat, rd, err);
    check("mask0_latency", lat, 3);
    req_a(0, 32'h14, 0, 0, lat, rd, err);
    check("mask0_unchanged", rd, 32'hFF22_FF44);

    req_a(1, 32'h20, 32'hCAFE_F00D, 4'hF, lat, rd, err);
    a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678; a_be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_drops_resp", a_resp, 0);
    @(negedge clk);
    rst = 1'b0;
    a_write = 1'b0;
    hits = 0;
    repeat (6) begin @(posedge clk); #1; hits += int'(a_resp); end
    check("aborted_no_resp", hits, 0);
    req_a(0, 32'h20, 0, 0, lat, rd, err);
    check("aborted_write_discarded", rd, 32'hCAFE_F00D);

    for (int k = 1; k <= 3; k++) begin
      req_b(1, 32'(4 * k), bval[k], 4'hF, lat);
      check("b_wr_latency", lat, 1);
    end
    b_read = 1'b1; b_addr = 32'h4;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_resp_c%0d", k), b_resp, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) begin
        check($sformatf("b2b_rdata_c%0d", k), b_rdata, bval[(k + 1) / 2]);
        b_addr = 32'(4 * ((k + 1) / 2 + 1));
        if (k == 5) b_read = 1'b0;
      end
    end

    req_a(1, 32'h0, 32'hA5A5_0000, 4'hF, lat, rd, err);
    req_a(1, 32'h40, 32'h0BAD_F00D, 4'hF, lat, rd, err);
    check("oob_wr_latency", lat, 3);
    check("oob_wr_err", err, ERR_EN);
    req_a(0, 32'h0, 0, 0, lat, rd, err);
    check("oob_word0", rd, ERR_EN ? 32'hA5A5_0000 : 32'h0BAD_F00D);
    req_a(0, 32'h40, 0, 0, lat, rd, err);
    check("oob_rd_data", rd, ERR_EN ? 32'h0 : 32'h0BAD_F00D);
    check("oob_rd_err", err, ERR_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I pipeline: the memory side of the `read` / `write` / `rv32i_mem_wmask` request interface that the MEM stage drives from its control word. It latches one request at a time, serves it from an internal word array after a fixed, parameterised latency, and answers with a single-cycle `mem_resp`. It serves as the behavioural data memory in core-level simulation and as a latency-injecting stand-in for the cache.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, default 3: cycles from request sample to `mem_resp`; integer ≥ 1.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; word aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_read` in 1: read request; held high until the cycle `mem_resp` is seen.
- `mem_write` in 1: write request; same hold rule.
- `mem_address` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data (`rv32i_word`).
- `mem_byte_enable` in 4: write lane mask (`rv32i_mem_wmask`); bit i enables bits [8i+7:8i].
- `mem_rdata` out 32: read data; registered.
- `mem_resp` out 1: completion pulse; registered.
- `mem_err` out 1: error pulse, coincident with `mem_resp`; present only under `DMEM_ERR_EN`.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if `mem_read | mem_write`, latch address, wdata, mask and kind. If `LATENCY == 1`, go to DONE; else load `cnt = LATENCY-2` and go to WAIT.
- WAIT: if `cnt == 0`, go to DONE; else decrement `cnt`.
- DONE: `mem_resp = 1`. Return to IDLE unconditionally.
- Word index is `(addr - BASE_ADDR) >> 2`. The counter is $clog2(LATENCY) bits wide, minimum 1.
- Write commit happens on the clock edge that enters DONE. Only enabled lanes are updated. `mem_rdata` is not changed by writes.
- Read data: `mem_rdata` is loaded on the clock edge that enters DONE. It holds its value until the next read completes.
- `mem_read` and `mem_write` both high is treated as a write.
- Inputs that change after the request is sampled are ignored until the responder is back in IDLE.
- Requests still high in the cycle after DONE are sampled as a new request, so back-to-back operation is legal.
- A write with a mask of 4'b0000 completes normally and changes no memory.
- Reset values: state IDLE, `cnt` 0, `mem_resp` 0, `mem_rdata` 32'h0, `mem_err` 0. Array contents are not reset.

## Timing
- Request high in cycle 0 (sampled at the end of cycle 0) → `mem_resp` high in cycle `LATENCY`, for exactly one cycle.
- Back-to-back: the next request can be sampled in cycle `LATENCY+1`; its response comes in cycle `2*LATENCY+1`.
- Throughput is one access per `LATENCY+1` cycles.
- `rst` asserted mid-operation forces IDLE immediately and drops `mem_resp` asynchronously.
  - A write not yet committed is discarded.
  - Committed data persists.
  - No `mem_resp` is issued for the aborted request.

## Configuration
- Macro `DMEM_ERR_EN` defined:
  - An address below `BASE_ADDR`, or at or above `BASE_ADDR + 4*DEPTH_WORDS`, still completes at normal latency.
  - `mem_err = 1` with `mem_resp`.
  - Writes are suppressed.
  - `mem_rdata` is loaded with 32'h0.
- Macro undefined:
  - The `mem_err` port is absent.
  - The index is truncated to $clog2(DEPTH_WORDS) bits, so out-of-range addresses wrap modulo the array size.

## Structure
- Package `rv32i_types` provides `rv32i_word` and `rv32i_mem_wmask`.
- Add `dmem_state_t` (IDLE/WAIT/DONE) to `rv32i_types` so the core-level monitor can decode it.
- Sub-module `dmem_array`: a synchronous single-port word array with per-byte write enables and a registered read port. The FSM, counter and request latches stay in `dmem_responder`.

## Test plan
- **Reset:** `rst` high for 2 cycles → `mem_resp` 0, `mem_rdata` 0. Release; with no request, `mem_resp` stays 0 for 20 cycles.
- **Write then read, LATENCY=3:**
  - Write 32'hDEAD_BEEF, mask 4'hF, to 0x10 → `mem_resp` in cycle 3 only.
  - Read 0x10 → `mem_rdata` = 32'hDEAD_BEEF in its resp cycle.
- **Byte lanes:**
  - Write 32'h1122_3344 with mask 4'b0101 over 32'hFFFF_FFFF.
  - Read back → 32'hFF22_FF44.
  - Mask 4'b0000 → word unchanged, `mem_resp` still pulses.
- **Back-to-back, LATENCY=1:** hold `mem_read` high continuously → `mem_resp` in cycles 1, 3, 5. `mem_rdata` tracks the latched addresses.
- **Reset mid-write:** write 0x20 with `rst` pulsed in cycle 1 at LATENCY=3 → no `mem_resp`; a later read of 0x20 returns the prior value.
- **Out of range:** address `BASE_ADDR + 4*DEPTH_WORDS`.
  - With `DMEM_ERR_EN`: `mem_err` with `mem_resp`, rdata 0, no write.
  - Without: access aliases word 0.
